// File: rtl/ecc_periph_regs.sv
// ecc_periph_regs -- memory-mapped register front-end for the ECC point-multiply
// engine. Holds the K/PX/PY operands, launches the engine with a start/done
// handshake, latches the RX/RY result and reports status, a cycle count and a
// level interrupt.
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-high reset
//   req_i/we_i/addr_i/
//   wdata_i/be_i             bus request (byte address, 64-bit data, byte enables)
//   gnt_o                    grant, combinational copy of req_i
//   rvalid_o/rdata_o/err_o   response, one cycle after the request
//   eng_start_o              one-cycle launch pulse
//   eng_k_o/eng_px_o/eng_py_o operands (frozen while busy)
//   eng_done_i/eng_err_i     completion pulse and fault flag
//   eng_rx_i/eng_ry_i        result point
//   irq_o                    level interrupt = STATUS.DONE & CTRL.IRQ_EN
//
// Map (offset from BaseAddr): 0x000 CTRL, 0x008 STATUS, 0x010 CYCLES,
// 0x100 K, 0x120 PX, 0x140 PY, 0x200 RX, 0x220 RY (4 words each, word 0 = LSW).
module ecc_periph_regs #(
  parameter logic [63:0] BaseAddr      = 64'h5000_0000,
  parameter logic [63:0] Length        = 64'h1000,
  parameter int          OpWidth       = 256,
  parameter logic [31:0] TimeoutCycles = 32'd1_000_000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [63:0]        addr_i,
  input  logic [63:0]        wdata_i,
  input  logic [7:0]         be_i,
  output logic               gnt_o,
  output logic               rvalid_o,
  output logic [63:0]        rdata_o,
  output logic               err_o,
  output logic               eng_start_o,
  output logic [OpWidth-1:0] eng_k_o,
  output logic [OpWidth-1:0] eng_px_o,
  output logic [OpWidth-1:0] eng_py_o,
  input  logic               eng_done_i,
  input  logic               eng_err_i,
  input  logic [OpWidth-1:0] eng_rx_i,
  input  logic [OpWidth-1:0] eng_ry_i,
  output logic               irq_o
);

  // Operand words; the map reserves four word slots per operand, so
  // storage is sized for four and only the low NW words are ever writable.
  localparam int         NW  = OpWidth / 64;
  localparam logic [2:0] NW3 = 3'(NW);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0][63:0]  r_k, r_px, r_py, r_rx, r_ry;
  logic              r_irq_en, r_busy, r_done, r_err, r_tmo;
  logic [63:0]       r_cycles;
  logic [31:0]       r_cnt;
  logic              r_rvalid, r_errq, r_irq;
  logic [63:0]       r_rdata;

  // ---------------- address decode ----------------
  logic [63:0] w_off;
  logic [58:0] w_blk;
  logic [1:0]  w_idx;
  logic        w_in_win, w_idx_ok;
  logic        w_ctrl, w_stat, w_cyc, w_k, w_px, w_py, w_rx, w_ry;
  logic        w_mapped, w_ro, w_opnd, w_err, w_wr, w_rd;

  assign w_off    = addr_i - BaseAddr;
  assign w_blk    = w_off[63:5];
  assign w_idx    = w_off[4:3];
  assign w_in_win = (addr_i >= BaseAddr) && (w_off < Length);
  assign w_idx_ok = {1'b0, w_idx} < NW3;

  assign w_ctrl = (w_off == 64'h000);
  assign w_stat = (w_off == 64'h008);
  assign w_cyc  = (w_off == 64'h010);
  assign w_k    = (w_blk == 59'h08) && w_idx_ok;
  assign w_px   = (w_blk == 59'h09) && w_idx_ok;
  assign w_py   = (w_blk == 59'h0A) && w_idx_ok;
  assign w_rx   = (w_blk == 59'h10) && w_idx_ok;
  assign w_ry   = (w_blk == 59'h11) && w_idx_ok;

  assign w_opnd   = w_k | w_px | w_py;
  assign w_ro     = w_stat | w_cyc | w_rx | w_ry;
  assign w_mapped = w_ctrl | w_ro | w_opnd;

  // Any error drops the whole access: no register changes, zero read data.
  assign w_err = req_i & ( ~w_in_win
                         | (addr_i[2:0] != 3'b000)
                         | ~w_mapped
                         | (we_i & w_ro)
                         | (we_i & w_opnd & r_busy)
                         | (we_i & w_ctrl & be_i[0] & wdata_i[0] & r_busy));
  assign w_wr  = req_i &  we_i & ~w_err;
  assign w_rd  = req_i & ~we_i & ~w_err;

  function automatic logic [63:0] f_merge(input logic [63:0] old,
                                          input logic [63:0] wd,
                                          input logic [7:0]  be);
    logic [63:0] m;
    m = old;
    for (int b = 0; b < 8; b++)
      if (be[b]) m[b*8 +: 8] = wd[b*8 +: 8];
    return m;
  endfunction

  // ---------------- control / status next state ----------------
  logic w_start, w_clr, w_fin_done, w_fin_tmo;
  logic w_busy_n, w_done_n, w_err_n, w_tmo_n, w_irq_en_n;

  assign w_start    = w_wr & w_ctrl & be_i[0] & wdata_i[0] & (r_state == S_IDLE);
  assign w_clr      = w_wr & w_ctrl & be_i[1] & wdata_i[8];
  assign w_fin_done = (r_state == S_WAIT) & eng_done_i;
  // Done in the same cycle as the timeout takes precedence.
  assign w_fin_tmo  = (r_state == S_WAIT) & ~eng_done_i &
                      (r_cnt == TimeoutCycles - 32'd1);

  always_comb begin
    w_busy_n   = r_busy;
    w_done_n   = r_done;
    w_err_n    = r_err;
    w_tmo_n    = r_tmo;
    w_irq_en_n = r_irq_en;
    if (w_wr && w_ctrl && be_i[0]) w_irq_en_n = wdata_i[1];
    // Clear first so a coincident completion set wins.
    if (w_clr) w_done_n = 1'b0;
    if (w_fin_done) begin
      w_busy_n = 1'b0;
      w_done_n = 1'b1;
      w_err_n  = eng_err_i;
    end
    if (w_fin_tmo) begin
      w_busy_n = 1'b0;
      w_done_n = 1'b1;
      w_err_n  = 1'b1;
      w_tmo_n  = 1'b1;
    end
    // Start wins over a CLR_DONE in the same write.
    if (w_start) begin
      w_busy_n = 1'b1;
      w_done_n = 1'b0;
      w_err_n  = 1'b0;
      w_tmo_n  = 1'b0;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    eng_start_o = 1'b0;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = S_LAUNCH;
      S_LAUNCH: begin
        eng_start_o = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT:   if (w_fin_done || w_fin_tmo) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- read mux ----------------
  logic [63:0] w_rd_val;
  always_comb begin
    w_rd_val = '0;
    if (w_ctrl)      w_rd_val = {62'b0, r_irq_en, 1'b0};
    else if (w_stat) w_rd_val = {60'b0, r_tmo, r_err, r_done, r_busy};
    else if (w_cyc)  w_rd_val = r_cycles;
    else if (w_k)    w_rd_val = r_k[w_idx];
    else if (w_px)   w_rd_val = r_px[w_idx];
    else if (w_py)   w_rd_val = r_py[w_idx];
    else if (w_rx)   w_rd_val = r_rx[w_idx];
    else if (w_ry)   w_rd_val = r_ry[w_idx];
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_k      <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_rx     <= '0;
      r_ry     <= '0;
      r_irq_en <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_tmo    <= 1'b0;
      r_cycles <= '0;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
      r_errq   <= 1'b0;
      r_rdata  <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && w_k)  r_k[w_idx]  <= f_merge(r_k[w_idx],  wdata_i, be_i);
      if (w_wr && w_px) r_px[w_idx] <= f_merge(r_px[w_idx], wdata_i, be_i);
      if (w_wr && w_py) r_py[w_idx] <= f_merge(r_py[w_idx], wdata_i, be_i);

      if (w_fin_done) begin
        r_rx[NW-1:0] <= eng_rx_i;
        r_ry[NW-1:0] <= eng_ry_i;
        r_cycles     <= {32'b0, r_cnt + 32'd1};
      end

      if (w_start)                                       r_cnt <= '0;
      else if (r_state == S_WAIT && !w_fin_done && !w_fin_tmo) r_cnt <= r_cnt + 32'd1;

      r_irq_en <= w_irq_en_n;
      r_busy   <= w_busy_n;
      r_done   <= w_done_n;
      r_err    <= w_err_n;
      r_tmo    <= w_tmo_n;
      r_irq    <= w_done_n & w_irq_en_n;

      r_rvalid <= req_i;
      r_errq   <= w_err;
      r_rdata  <= w_rd ? w_rd_val : 64'h0;
    end
  end

  assign gnt_o    = req_i;
  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_errq;
  assign irq_o    = r_irq;
  assign eng_k_o  = r_k[NW-1:0];
  assign eng_px_o = r_px[NW-1:0];
  assign eng_py_o = r_py[NW-1:0];

endmodule

// File: tb/tb_ecc_periph_regs.sv
// Directed bench for ecc_periph_regs. The watchdog is shortened to 128 cycles
// so the 100-cycle normal operation completes and the timeout case stays short.
module tb_ecc_periph_regs;
  localparam int OW = 256;
  localparam logic [63:0] B      = 64'h5000_0000;
  localparam logic [63:0] A_CTRL = B + 64'h000;
  localparam logic [63:0] A_STAT = B + 64'h008;
  localparam logic [63:0] A_CYC  = B + 64'h010;
  localparam logic [63:0] A_K    = B + 64'h100;
  localparam logic [63:0] A_PX   = B + 64'h120;
  localparam logic [63:0] A_PY   = B + 64'h140;
  localparam logic [63:0] A_RX   = B + 64'h200;
  localparam logic [63:0] A_RY   = B + 64'h220;

  logic          clk = 1'b0;
  logic          rst;
  logic          req, we;
  logic [63:0]   addr, wdata;
  logic [7:0]    be;
  logic          gnt, rvalid, err, eng_start, eng_done, eng_err, irq;
  logic [63:0]   rdata;
  logic [OW-1:0] eng_k, eng_px, eng_py, eng_rx, eng_ry;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;

  logic        rv, re;
  logic [63:0] rd;

  always #5 clk = ~clk;

  ecc_periph_regs #(.TimeoutCycles(32'd128)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .err_o(err), .eng_start_o(eng_start),
    .eng_k_o(eng_k), .eng_px_o(eng_px), .eng_py_o(eng_py),
    .eng_done_i(eng_done), .eng_err_i(eng_err), .eng_rx_i(eng_rx),
    .eng_ry_i(eng_ry), .irq_o(irq)
  );

  always @(posedge clk) if (eng_start) start_cnt <= start_cnt + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus transaction, driven on a falling edge; response captured on the next.
  task automatic access(input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] b);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    rv = rvalid; re = err; rd = rdata;
  endtask

  task automatic rd_ok(input string tag, input logic [63:0] a, input logic [63:0] exp);
    access(1'b0, a, 64'h0, 8'h00);
    chk({tag, " data"}, rd, exp);
    chk({tag, " err"}, re, 1'b0);
  endtask

  task automatic rd_bad(input string tag, input logic [63:0] a);
    access(1'b0, a, 64'h0, 8'h00);
    chk({tag, " err"}, re, 1'b1);
    chk({tag, " data"}, rd, 64'h0);
  endtask

  task automatic wr_ok(input string tag, input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] b);
    access(1'b1, a, d, b);
    chk({tag, " err"}, re, 1'b0);
  endtask

  task automatic wr_bad(input string tag, input logic [63:0] a, input logic [63:0] d);
    access(1'b1, a, d, 8'hFF);
    chk({tag, " err"}, re, 1'b1);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    eng_done = 1'b0; eng_err = 1'b0; eng_rx = '0; eng_ry = '0;
    repeat (2) @(negedge clk);
    chk("rst rvalid", rvalid, 1'b0);
    chk("rst rdata", rdata, 64'h0);
    chk("rst err", err, 1'b0);
    chk("rst start", eng_start, 1'b0);
    chk("rst irq", irq, 1'b0);
    chk("rst eng_k", eng_k, '0);
    rst = 1'b0;
    @(negedge clk);

    // ---- register access ----
    req = 1'b1; #1 chk("gnt", gnt, 1'b1); req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_ok($sformatf("wK%0d", i), A_K + 64'(8*i), 64'(i + 1), 8'hFF);
      wr_ok($sformatf("wPX%0d", i), A_PX + 64'(8*i), 64'hA5A5_0000_0000_0000 + 64'(i), 8'hFF);
      wr_ok($sformatf("wPY%0d", i), A_PY + 64'(8*i), 64'h0000_5A5A_0000_0000 + 64'(i << 8), 8'hFF);
    end
    access(1'b0, A_K, 64'h0, 8'h00);
    chk("rvalid", rv, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rd_ok($sformatf("rK%0d", i), A_K + 64'(8*i), 64'(i + 1));
      rd_ok($sformatf("rPX%0d", i), A_PX + 64'(8*i), 64'hA5A5_0000_0000_0000 + 64'(i));
      rd_ok($sformatf("rPY%0d", i), A_PY + 64'(8*i), 64'h0000_5A5A_0000_0000 + 64'(i << 8));
    end
    wr_ok("wK0 be0F", A_K, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    rd_ok("rK0 be0F", A_K, 64'h0000_0000_FFFF_FFFF);
    chk("eng_k w0", eng_k[63:0], 64'h0000_0000_FFFF_FFFF);
    chk("eng_k w3", eng_k[255:192], 64'h4);
    chk("eng_px w2", eng_px[191:128], 64'hA5A5_0000_0000_0002);

    // ---- normal operation with busy protection during WAIT ----
    wr_ok("start", A_CTRL, 64'h3, 8'hFF);        // now in LAUNCH
    chk("start pulse", eng_start, 1'b1);
    wr_bad("K0 busy", A_K, 64'h1234);            // WAIT cycle 1
    chk("start low", eng_start, 1'b0);
    wr_bad("START busy", A_CTRL, 64'h1);
    rd_ok("K0 kept", A_K, 64'h0000_0000_FFFF_FFFF);
    rd_ok("stat busy", A_STAT, 64'h1);
    repeat (96) @(negedge clk);                  // WAIT cycle 100
    eng_rx = {4{64'hAAAA_AAAA_AAAA_AAAA}};
    eng_ry = {4{64'h5555_5555_5555_5555}};
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    chk("irq set", irq, 1'b1);
    chk("one pulse", 32'(start_cnt), 32'd1);
    rd_ok("stat done", A_STAT, 64'h2);
    rd_ok("cycles", A_CYC, 64'd100);
    rd_ok("RX0", A_RX, 64'hAAAA_AAAA_AAAA_AAAA);
    rd_ok("RY3", A_RY + 64'h18, 64'h5555_5555_5555_5555);
    rd_ok("ctrl rd", A_CTRL, 64'h2);
    wr_ok("clr", A_CTRL, 64'h102, 8'hFF);
    chk("irq clr", irq, 1'b0);
    rd_ok("stat clr", A_STAT, 64'h0);

    // ---- timeout ----
    eng_rx = {4{64'h7777_7777_7777_7777}};
    wr_ok("start2", A_CTRL, 64'h1, 8'hFF);
    repeat (127) @(negedge clk);
    rd_ok("stat wait127", A_STAT, 64'h1);
    rd_ok("stat tmo edge", A_STAT, 64'h1);
    rd_ok("stat tmo", A_STAT, 64'hE);
    rd_ok("RX0 kept", A_RX, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("irq off", irq, 1'b0);
    chk("two pulses", 32'(start_cnt), 32'd2);

    // ---- bad addresses ----
    rd_bad("past end", 64'h5000_1000);
    rd_bad("misalign", 64'h5000_0004);
    rd_bad("unmapped", 64'h5000_0300);
    rd_bad("below base", 64'h4FFF_FFF8);
    wr_bad("wr STATUS", A_STAT, 64'h0);
    rd_ok("stat kept", A_STAT, 64'hE);

    // ---- CLR_DONE coincident with eng_done ----
    wr_ok("start3", A_CTRL, 64'h1, 8'hFF);
    repeat (5) @(negedge clk);
    eng_done = 1'b1; eng_err = 1'b1;
    access(1'b1, A_CTRL, 64'h100, 8'hFF);
    eng_done = 1'b0; eng_err = 1'b0;
    chk("race err", re, 1'b0);
    rd_ok("stat race", A_STAT, 64'h6);
    rd_ok("cycles race", A_CYC, 64'd5);

    // ---- reset during WAIT ----
    wr_ok("start4", A_CTRL, 64'h3, 8'hFF);
    repeat (3) @(negedge clk);
    chk("four pulses", 32'(start_cnt), 32'd4);
    req = 1'b1; we = 1'b0; addr = A_STAT; be = 8'h00;
    @(negedge clk);
    chk("pre-rst rvalid", rvalid, 1'b1);
    chk("pre-rst data", rdata, 64'h1);
    rst = 1'b1;
    #1;
    chk("mid-rst rvalid", rvalid, 1'b0);
    chk("mid-rst rdata", rdata, 64'h0);
    chk("mid-rst err", err, 1'b0);
    chk("mid-rst start", eng_start, 1'b0);
    chk("mid-rst irq", irq, 1'b0);
    chk("mid-rst eng_k", eng_k, '0);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    rd_ok("stat post-rst", A_STAT, 64'h0);
    rd_ok("K0 post-rst", A_K, 64'h0);
    rd_ok("RX0 post-rst", A_RX, 64'h0);
    chk("no pulse post-rst", 32'(start_cnt), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
